// File: rtl/test_tx.sv
// test_tx : test-pattern frame generator for the MAC transmit path.
//
// Emits back-to-back frames of scrambler data with sof/eof marking and
// valid/rdy flow control. The scrambler is reseeded only when a run starts
// from IDLE. Between frames of the same run it keeps running, so a checker
// that is seeded the same way stays aligned with this generator. A
// single-word corruption (bit 0 inverted) can be injected to exercise the
// checker's compare-error path.
//
// Ports
//   clk_i           clock
//   rst_i           asynchronous, active-high reset
//   start_i         level: run while high; on deassert finish the frame, then stop
//   frame_len_i     words per frame (0 treated as 1)
//   err_inject_i    pulse: invert bit 0 of the next accepted word
//   mac_tx_data_o   payload word
//   mac_tx_valid_o  word valid
//   mac_tx_sof_o    first word of frame
//   mac_tx_eof_o    last word of frame
//   mac_tx_rdy_i    sink accepts word when valid & rdy
//   busy_o          high in any state except IDLE
//   frame_done_o    1-cycle pulse the cycle after an eof word is accepted
//   frame_cnt_o     frames completed since reset (wraps)
//
// FSM states
//   state  | meaning
//   IDLE   | stopped, outputs quiet; start reseeds scrambler
//   INIT   | one cycle after reseed; latch frame length
//   TX     | presenting words; advance on each accepted word
//   GAP    | idle spacing between frames; decide next frame or stop

// sata_scrambler : 16-bit LFSR (x^16+x^15+x^13+x^4+1) that produces 32 bits
// per step. result_o is the word for the current state. en_i advances the
// state by 32 bits. sof_i reloads the seed.
//
// Ports
//   clk_i     clock
//   rst_i     asynchronous, active-high reset (state := seed)
//   sof_i     reload seed
//   en_i      advance one word
//   result_o  current 32-bit scrambler word
module sata_scrambler #(
  parameter logic [15:0] G_INIT_VAL = 16'h55AA
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sof_i,
  input  logic        en_i,
  output logic [31:0] result_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [15:0] lfsr_adv;
  logic [31:0] word;

  // Serial unrolling: each output bit is the LFSR MSB, then shift in feedback.
  always_comb begin
    lfsr_adv = lfsr_q;
    word     = '0;
    for (int i = 0; i < 32; i++) begin
      word[i]  = lfsr_adv[15];
      lfsr_adv = {lfsr_adv[14:0],
                  lfsr_adv[15] ^ lfsr_adv[14] ^ lfsr_adv[12] ^ lfsr_adv[3]};
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (sof_i) begin
      lfsr_d = G_INIT_VAL;
    end else if (en_i) begin
      lfsr_d = lfsr_adv;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= G_INIT_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign result_o = word;

endmodule

module test_tx #(
  parameter int TEST_DATA_WIDTH = 32,
  parameter int GAP_LEN         = 4,
  parameter int FRAME_CNT_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [15:0]                frame_len_i,
  input  logic                       err_inject_i,
  output logic [TEST_DATA_WIDTH-1:0] mac_tx_data_o,
  output logic                       mac_tx_valid_o,
  output logic                       mac_tx_sof_o,
  output logic                       mac_tx_eof_o,
  input  logic                       mac_tx_rdy_i,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic [FRAME_CNT_W-1:0]     frame_cnt_o
);

  localparam int GAP_EFF = (GAP_LEN < 1) ? 1 : GAP_LEN;
  localparam int GAP_W   = $clog2(GAP_EFF + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_TX   = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            word_cnt_q, word_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   valid_q, valid_d;
  logic                   sof_q, sof_d;
  logic                   eof_q, eof_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_inj_q, err_inj_d;

  logic                   beat;
  logic                   scr_sof;
  logic [15:0]            len_in;
  logic [31:0]            scr_word;
  logic [31:0]            data_full;

  assign beat    = valid_q & mac_tx_rdy_i;
  assign scr_sof = (state_q == S_IDLE) & start_i;
  assign len_in  = (frame_len_i == 16'd0) ? 16'd1 : frame_len_i;

  sata_scrambler #(
    .G_INIT_VAL (16'h55AA)
  ) u_scrambler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sof_i    (scr_sof),
    .en_i     (beat),
    .result_o (scr_word)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    // A pending injection survives stalls and stops; only an accepted word consumes it.
    err_inj_d    = (err_inj_q & ~beat) | err_inject_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (start_i) begin
          len_d      = len_in;
          word_cnt_d = 16'd0;
          state_d    = S_TX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (beat) begin
          if (eof_q) begin
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
            frame_done_d = 1'b1;
            gap_cnt_d    = GAP_W'(GAP_EFF);
            word_cnt_d   = 16'd0;
            state_d      = S_GAP;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          if (start_i) begin
            len_d      = len_in;
            word_cnt_d = 16'd0;
            state_d    = S_TX;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the next-state values.
    valid_d = (state_d == S_TX);
    sof_d   = valid_d && (word_cnt_d == 16'd0);
    eof_d   = valid_d && (word_cnt_d == (len_d - 16'd1));
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd1;
      word_cnt_q   <= 16'd0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_inj_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      valid_q      <= valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_inj_q    <= err_inj_d;
    end
  end

  // Data is forced to zero when not valid so the bus is quiet in reset and idle.
  always_comb begin
    data_full    = scr_word;
    data_full[0] = scr_word[0] ^ err_inj_q;
  end

  assign mac_tx_data_o  = valid_q ? data_full[TEST_DATA_WIDTH-1:0] : '0;
  assign mac_tx_valid_o = valid_q;
  assign mac_tx_sof_o   = sof_q;
  assign mac_tx_eof_o   = eof_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = frame_done_q;
  assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_test_tx.sv
module tb_test_tx;

  localparam int          W    = 32;
  localparam int          GAP  = 4;
  localparam int          FCW  = 32;
  localparam logic [15:0] SEED = 16'h55AA;
  localparam int          NBIT = 4096;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [15:0]    frame_len = 16'd4;
  logic           err_inject = 1'b0;
  logic           mac_tx_rdy = 1'b1;
  logic [W-1:0]   mac_tx_data;
  logic           mac_tx_valid;
  logic           mac_tx_sof;
  logic           mac_tx_eof;
  logic           busy;
  logic           frame_done;
  logic [FCW-1:0] frame_cnt;

  test_tx #(
    .TEST_DATA_WIDTH (W),
    .GAP_LEN         (GAP),
    .FRAME_CNT_W     (FCW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .frame_len_i    (frame_len),
    .err_inject_i   (err_inject),
    .mac_tx_data_o  (mac_tx_data),
    .mac_tx_valid_o (mac_tx_valid),
    .mac_tx_sof_o   (mac_tx_sof),
    .mac_tx_eof_o   (mac_tx_eof),
    .mac_tx_rdy_i   (mac_tx_rdy),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .frame_cnt_o    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         sof;
    logic         eof;
    int           gap;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pops    = 0;
  int   eofs    = 0;
  bit   stall_en = 1'b0;
  logic seq_bits [NBIT];

  // Scrambler output bit stream as a linear recurrence on the output bits:
  // the first 16 bits are the seed MSB-first, then
  // o[n+16] = o[n] ^ o[n+1] ^ o[n+3] ^ o[n+12].
  initial begin
    for (int i = 0; i < 16; i++) seq_bits[i] = SEED[15-i];
    for (int n = 0; n < NBIT - 16; n++)
      seq_bits[n+16] = seq_bits[n] ^ seq_bits[n+1] ^ seq_bits[n+3] ^ seq_bits[n+12];
  end

  function automatic logic [W-1:0] model_word(input int idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = seq_bits[idx*32 + i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Ready driver: random 50% stalls when enabled, otherwise always ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mac_tx_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t           e;
    logic [W-1:0]   h_data;
    logic           h_sof;
    logic           h_eof;
    bit             hold = 1'b0;
    bit             done_pend = 1'b0;
    int             idle_cnt = 0;
    logic [FCW-1:0] exp_fc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold      = 1'b0;
        done_pend = 1'b0;
        idle_cnt  = 0;
        exp_fc    = '0;
        continue;
      end
      if (done_pend) begin
        chk("frame_done_pulse", frame_done, 1);
        chk("frame_cnt", frame_cnt, exp_fc);
        done_pend = 1'b0;
      end else begin
        chk("frame_done_quiet", frame_done, 0);
      end
      if (hold) begin
        chk("stall_valid_held", mac_tx_valid, 1);
        chk("stall_data_held", mac_tx_data, h_data);
        chk("stall_sof_held", mac_tx_sof, h_sof);
        chk("stall_eof_held", mac_tx_eof, h_eof);
      end
      if (!mac_tx_valid) idle_cnt++;
      if (mac_tx_valid && mac_tx_rdy) begin
        if (q.size() == 0) begin
          chk("beat_with_empty_queue", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("data", mac_tx_data, e.data);
          chk("sof", mac_tx_sof, e.sof);
          chk("eof", mac_tx_eof, e.eof);
          if (e.gap > 0) chk("gap_len", idle_cnt, e.gap);
          pops++;
          if (e.eof) begin
            eofs++;
            exp_fc    = exp_fc + 1'b1;
            done_pend = 1'b1;
            idle_cnt  = 0;
          end
        end
      end
      hold   = mac_tx_valid && !mac_tx_rdy;
      h_data = mac_tx_data;
      h_sof  = mac_tx_sof;
      h_eof  = mac_tx_eof;
    end
  end

  task automatic wait_pops(input int target, input string name);
    int c = 0;
    while (pops < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk(name, (pops >= target), 1);
  endtask

  task automatic wait_eofs(input int target, input string name);
    int c = 0;
    while (eofs < target && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk(name, (eofs >= target), 1);
  endtask

  // Run nfr frames from IDLE (fresh seed), drop start during word drop_at of
  // the last frame, optionally inject an error into frame inj_frame.
  task automatic send(input int nfr, input int len, input int drop_at, input int inj_frame);
    int   leff;
    int   base_p;
    int   base_e;
    int   c;
    exp_t e;
    leff   = (len == 0) ? 1 : len;
    base_p = pops;
    base_e = eofs;
    for (int f = 0; f < nfr; f++) begin
      for (int w = 0; w < leff; w++) begin
        e.data = model_word(f*leff + w);
        if (f == inj_frame && w == 0) e.data[0] = ~e.data[0];
        e.sof = (w == 0);
        e.eof = (w == leff - 1);
        e.gap = (f > 0 && w == 0) ? GAP : 0;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    frame_len = 16'(len);
    start     = 1'b1;
    if (inj_frame > 0) begin
      wait_eofs(base_e + inj_frame, "reach_gap_for_inject");
      @(posedge clk);
      #1 err_inject = 1'b1;
      @(posedge clk);
      #1 err_inject = 1'b0;
    end
    wait_pops(base_p + (nfr-1)*leff + drop_at + 1, "reach_stop_word");
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    while (busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("busy_after_stop", busy, 0);
    chk("valid_after_stop", mac_tx_valid, 0);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int   base_p;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", mac_tx_valid, 0);
    chk("rst_sof", mac_tx_sof, 0);
    chk("rst_eof", mac_tx_eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_data", mac_tx_data, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Plain frames of 4, always ready.
    send(3, 4, 0, -1);
    // Same stream under random back-pressure.
    stall_en = 1'b1;
    send(3, 4, 0, -1);
    stall_en = 1'b0;
    // Single-word frames.
    send(2, 1, 0, -1);
    send(2, 0, 0, -1);
    // Stop requested early in an 8-word frame.
    send(1, 8, 1, -1);
    // Injected error on first word of second frame.
    send(2, 4, 0, 1);

    // Reset in the middle of a frame.
    for (int w = 0; w < 8; w++) begin
      e.data = model_word(w);
      e.sof  = (w == 0);
      e.eof  = (w == 7);
      e.gap  = 0;
      q.push_back(e);
    end
    base_p = pops;
    @(posedge clk);
    #1;
    frame_len = 16'd8;
    start     = 1'b1;
    wait_pops(base_p + 3, "reach_mid_frame");
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    #1;
    chk("midrst_valid", mac_tx_valid, 0);
    chk("midrst_sof", mac_tx_sof, 0);
    chk("midrst_eof", mac_tx_eof, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(1, 4, 0, -1);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
